// File: rtl/spike_rate_decoder.sv
// spike_rate_decoder: counts spikes per channel over a programmable window,
// then scans the counts one channel per clock to find the most active
// channel and presents the result over a valid/ready handshake.
//
// Optional build macro: SPIKE_DECODER_SAT_EN
//   defined   -> per-channel counters saturate at 2^CNT_W-1
//   undefined -> per-channel counters wrap modulo 2^CNT_W
//   res_ovf is reported the same way in both builds.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   spikes_in    one spike line per channel, sampled each clk in ACCUM
//   enable       start a window from IDLE, or chain a new one after a handshake
//   clear        synchronous abort to IDLE (priority over everything else)
//   window_len   samples per window, latched at window start (0 -> 2^WIN_W)
//   res_valid    result available (HOLD)
//   res_ready    consumer accepts result
//   res_winner   lowest-index channel holding the highest count
//   res_count    count of the winning channel
//   res_tie      another channel equals the winning count
//   res_ovf      some counter was at max and received another spike
//   busy         high while accumulating or scanning
module spike_rate_decoder #(
    parameter int unsigned CHANNELS = 8,
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned WIN_W    = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [CHANNELS-1:0]         spikes_in,
    input  logic                        enable,
    input  logic                        clear,
    input  logic [WIN_W-1:0]            window_len,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic [$clog2(CHANNELS)-1:0] res_winner,
    output logic [CNT_W-1:0]            res_count,
    output logic                        res_tie,
    output logic                        res_ovf,
    output logic                        busy
);

    localparam int unsigned IDX_W  = $clog2(CHANNELS);
    localparam int unsigned WCNT_W = WIN_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_SCAN, S_HOLD} state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt [CHANNELS];
    logic [WCNT_W-1:0]  r_win;
    logic               r_ovf;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   r_arg;
    logic [CNT_W-1:0]   r_max;
    logic               r_tie;

    logic [CNT_W-1:0]   w_cnt_inc [CHANNELS];
    logic               w_ovf_hit;
    logic [WCNT_W-1:0]  w_win_load;
    logic [CNT_W-1:0]   w_cur;
    logic               w_first;
    logic               w_gt;
    logic               w_eq;
    logic               w_last;
    logic [CNT_W-1:0]   w_nmax;
    logic [IDX_W-1:0]   w_narg;
    logic               w_ntie;

    // A zero length field encodes the full 2^WIN_W window.
    assign w_win_load = (window_len == '0) ? {1'b1, {WIN_W{1'b0}}} : WCNT_W'(window_len);

    // Per-channel next count for one accumulation sample.
    always_comb begin
        w_ovf_hit = 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
            w_cnt_inc[c] = r_cnt[c];
            if (spikes_in[c]) begin
                if (r_cnt[c] == CNT_MAX) begin
                    w_ovf_hit = 1'b1;
`ifdef SPIKE_DECODER_SAT_EN
                    w_cnt_inc[c] = CNT_MAX;
`else
                    w_cnt_inc[c] = '0;
`endif
                end else begin
                    w_cnt_inc[c] = r_cnt[c] + CNT_W'(1);
                end
            end
        end
    end

    // Running argmax step; channel 0 seeds the max, later channels replace
    // it only when strictly greater so the lowest index keeps ties.
    assign w_cur   = r_cnt[r_idx];
    assign w_first = (r_idx == '0);
    assign w_gt    = w_first || (w_cur > r_max);
    assign w_eq    = !w_first && (w_cur == r_max);
    assign w_last  = (r_idx == IDX_W'(CHANNELS - 1));
    assign w_nmax  = w_gt ? w_cur : r_max;
    assign w_narg  = w_gt ? r_idx : r_arg;
    assign w_ntie  = w_gt ? 1'b0 : (w_eq ? 1'b1 : r_tie);

    // Control FSM, counters and registered result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            for (int c = 0; c < CHANNELS; c++) r_cnt[c] <= '0;
            r_win      <= '0;
            r_ovf      <= 1'b0;
            r_idx      <= '0;
            r_arg      <= '0;
            r_max      <= '0;
            r_tie      <= 1'b0;
            res_valid  <= 1'b0;
            res_winner <= '0;
            res_count  <= '0;
            res_tie    <= 1'b0;
            res_ovf    <= 1'b0;
            busy       <= 1'b0;
        end else if (clear) begin
            r_state   <= S_IDLE;
            for (int c = 0; c < CHANNELS; c++) r_cnt[c] <= '0;
            r_ovf     <= 1'b0;
            r_idx     <= '0;
            res_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (enable) begin
                        r_state <= S_ACCUM;
                        for (int c = 0; c < CHANNELS; c++) r_cnt[c] <= '0;
                        r_ovf   <= 1'b0;
                        r_win   <= w_win_load;
                        busy    <= 1'b1;
                    end
                end
                S_ACCUM: begin
                    r_cnt <= w_cnt_inc;
                    r_ovf <= r_ovf | w_ovf_hit;
                    r_win <= r_win - WCNT_W'(1);
                    if (r_win == WCNT_W'(1)) begin
                        r_state <= S_SCAN;
                        r_idx   <= '0;
                    end
                end
                S_SCAN: begin
                    r_max <= w_nmax;
                    r_arg <= w_narg;
                    r_tie <= w_ntie;
                    r_idx <= r_idx + IDX_W'(1);
                    if (w_last) begin
                        r_state    <= S_HOLD;
                        r_idx      <= '0;
                        res_valid  <= 1'b1;
                        res_winner <= w_narg;
                        res_count  <= w_nmax;
                        res_tie    <= w_ntie;
                        res_ovf    <= r_ovf;
                        busy       <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        if (enable) begin
                            r_state <= S_ACCUM;
                            for (int c = 0; c < CHANNELS; c++) r_cnt[c] <= '0;
                            r_ovf   <= 1'b0;
                            r_win   <= w_win_load;
                            busy    <= 1'b1;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Randomized bench for spike_rate_decoder: per-window spike totals are kept
// in plain integers and the expected result is derived from those totals.
module tb_spike_rate_decoder;

    localparam int unsigned CH = 8;
    localparam int unsigned CW = 8;
    localparam int unsigned WW = 8;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk;
    logic          rst_n;
    logic [CH-1:0] spikes_in;
    logic          enable;
    logic          clear;
    logic [WW-1:0] window_len;
    logic          res_valid;
    logic          res_ready;
    logic [2:0]    res_winner;
    logic [CW-1:0] res_count;
    logic          res_tie;
    logic          res_ovf;
    logic          busy;

    int n_checks;
    int n_fail;
    int mdl_n [CH];
    int exp_win;
    int exp_cnt;
    int exp_tie;
    int exp_ovf;

    spike_rate_decoder #(.CHANNELS(CH), .CNT_W(CW), .WIN_W(WW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .spikes_in  (spikes_in),
        .enable     (enable),
        .clear      (clear),
        .window_len (window_len),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_winner (res_winner),
        .res_count  (res_count),
        .res_tie    (res_tie),
        .res_ovf    (res_ovf),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    // Expected result from spike totals: stored count per channel, highest
    // value with lowest index, tie when more than one channel has that value.
    task automatic model_predict();
        int v [CH];
        int maxv;
        int neq;
        exp_ovf = 0;
        for (int c = 0; c < CH; c++) begin
            if (mdl_n[c] > CMAX) exp_ovf = 1;
`ifdef SPIKE_DECODER_SAT_EN
            v[c] = (mdl_n[c] > CMAX) ? CMAX : mdl_n[c];
`else
            v[c] = mdl_n[c] % (CMAX + 1);
`endif
        end
        maxv = -1;
        for (int c = 0; c < CH; c++) begin
            if (v[c] > maxv) begin
                maxv    = v[c];
                exp_win = c;
            end
        end
        neq = 0;
        for (int c = 0; c < CH; c++) if (v[c] == maxv) neq++;
        exp_cnt = maxv;
        exp_tie = (neq > 1) ? 1 : 0;
    endtask

    function automatic logic [CH-1:0] gen(input int mode, input int s);
        logic [CH-1:0] p;
        p = '0;
        case (mode)
            1: begin
                p[3] = 1'b1;
                if (s % 2 == 0) p[5] = 1'b1;
            end
            2: p[0] = 1'b1;
            3: begin
                if (s < 4) begin
                    p[2] = 1'b1;
                    p[6] = 1'b1;
                end
                if (s == 5 || s == 6) p[1] = 1'b1;
                if (s == 7) p[0] = 1'b1;
            end
            4: p = CH'($urandom & $urandom & $urandom);
            default: p = CH'($urandom);
        endcase
        return p;
    endfunction

    // Called at a negedge; the next edge starts a window (from IDLE or HOLD).
    task automatic start_win(input int len, input bit from_hold);
        enable     = 1'b1;
        window_len = WW'(len);
        res_ready  = from_hold;
        spikes_in  = CH'($urandom);
        @(negedge clk);
        res_ready = 1'b0;
        for (int c = 0; c < CH; c++) mdl_n[c] = 0;
        check_eq("start_busy", int'(busy), 1);
        check_eq("start_valid", int'(res_valid), 0);
    endtask

    task automatic feed(input int n, input int mode);
        for (int s = 0; s < n; s++) begin
            spikes_in  = gen(mode, s);
            window_len = WW'($urandom);
            enable     = 1'($urandom);
            for (int c = 0; c < CH; c++) if (spikes_in[c]) mdl_n[c]++;
            @(negedge clk);
        end
    endtask

    task automatic scan_wait();
        enable = 1'b0;
        for (int k = 1; k <= CH; k++) begin
            spikes_in = CH'($urandom);
            @(negedge clk);
            check_eq("scan_valid", int'(res_valid), (k == CH) ? 1 : 0);
            check_eq("scan_busy", int'(busy), (k == CH) ? 0 : 1);
        end
    endtask

    task automatic check_result(input string tag);
        model_predict();
        check_eq({tag, "_valid"}, int'(res_valid), 1);
        check_eq({tag, "_winner"}, int'(res_winner), exp_win);
        check_eq({tag, "_count"}, int'(res_count), exp_cnt);
        check_eq({tag, "_tie"}, int'(res_tie), exp_tie);
        check_eq({tag, "_ovf"}, int'(res_ovf), exp_ovf);
    endtask

    task automatic handshake_idle();
        enable    = 1'b0;
        res_ready = 1'b1;
        spikes_in = CH'($urandom);
        @(negedge clk);
        res_ready = 1'b0;
        check_eq("hs_valid", int'(res_valid), 0);
        check_eq("hs_busy", int'(busy), 0);
        check_eq("hs_hold_winner", int'(res_winner), exp_win);
        check_eq("hs_hold_count", int'(res_count), exp_cnt);
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        enable     = 1'b0;
        clear      = 1'b0;
        res_ready  = 1'b0;
        spikes_in  = '0;
        window_len = '0;
        #1;
        check_eq("rst_valid", int'(res_valid), 0);
        check_eq("rst_winner", int'(res_winner), 0);
        check_eq("rst_count", int'(res_count), 0);
        check_eq("rst_tie", int'(res_tie), 0);
        check_eq("rst_ovf", int'(res_ovf), 0);
        check_eq("rst_busy", int'(busy), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("idle_busy", int'(busy), 0);

        // Rate winner: ch3 every sample, ch5 every other sample.
        start_win(10, 1'b0);
        feed(10, 1);
        scan_wait();
        check_result("tp1");
        check_eq("tp1_const_winner", int'(res_winner), 3);
        check_eq("tp1_const_count", int'(res_count), 10);
        check_eq("tp1_const_tie", int'(res_tie), 0);
        handshake_idle();

        // Tie between ch2 and ch6.
        start_win(8, 1'b0);
        feed(8, 3);
        scan_wait();
        check_result("tp2");
        check_eq("tp2_const_winner", int'(res_winner), 2);
        check_eq("tp2_const_count", int'(res_count), 4);
        check_eq("tp2_const_tie", int'(res_tie), 1);
        handshake_idle();

        // Full 256-sample window with ch0 held high.
        start_win(0, 1'b0);
        feed(256, 2);
        scan_wait();
        check_result("tp3");
        check_eq("tp3_const_ovf", int'(res_ovf), 1);
`ifdef SPIKE_DECODER_SAT_EN
        check_eq("tp3_const_count", int'(res_count), 255);
        check_eq("tp3_const_tie", int'(res_tie), 0);
`else
        check_eq("tp3_const_count", int'(res_count), 0);
        check_eq("tp3_const_tie", int'(res_tie), 1);
`endif

        // Backpressure in HOLD while spikes toggle, then chain a new window.
        for (int i = 0; i < 20; i++) begin
            res_ready = 1'b0;
            enable    = 1'($urandom);
            spikes_in = CH'($urandom);
            @(negedge clk);
            check_eq("bp_valid", int'(res_valid), 1);
            check_eq("bp_winner", int'(res_winner), exp_win);
            check_eq("bp_count", int'(res_count), exp_cnt);
            check_eq("bp_tie", int'(res_tie), exp_tie);
            check_eq("bp_ovf", int'(res_ovf), exp_ovf);
        end
        start_win(12, 1'b1);
        feed(12, 0);
        scan_wait();
        check_result("tp4");
        handshake_idle();

        // Abort with clear at sample 5 of a 10-sample window.
        start_win(10, 1'b0);
        feed(5, 0);
        clear     = 1'b1;
        enable    = 1'b0;
        spikes_in = CH'($urandom);
        @(negedge clk);
        clear = 1'b0;
        check_eq("clr_busy", int'(busy), 0);
        check_eq("clr_valid", int'(res_valid), 0);
        for (int i = 0; i < 12; i++) begin
            spikes_in = CH'($urandom);
            @(negedge clk);
            check_eq("clr_idle_valid", int'(res_valid), 0);
        end
        start_win(10, 1'b0);
        feed(10, 0);
        scan_wait();
        check_result("tp5");

        // clear together with res_ready and enable in HOLD.
        clear     = 1'b1;
        res_ready = 1'b1;
        enable    = 1'b1;
        @(negedge clk);
        clear     = 1'b0;
        res_ready = 1'b0;
        enable    = 1'b0;
        check_eq("clrhs_valid", int'(res_valid), 0);
        check_eq("clrhs_busy", int'(busy), 0);
        @(negedge clk);
        check_eq("clrhs_idle_busy", int'(busy), 0);

        // Async reset in the middle of the scan.
        start_win(6, 1'b0);
        feed(6, 0);
        enable = 1'b0;
        for (int k = 0; k < 3; k++) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_valid", int'(res_valid), 0);
        check_eq("arst_winner", int'(res_winner), 0);
        check_eq("arst_count", int'(res_count), 0);
        check_eq("arst_tie", int'(res_tie), 0);
        check_eq("arst_ovf", int'(res_ovf), 0);
        check_eq("arst_busy", int'(busy), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check_eq("arst_no_result", int'(res_valid), 0);
        end
        start_win(9, 1'b0);
        feed(9, 0);
        scan_wait();
        check_result("tp6");
        handshake_idle();

        // Random windows with random backpressure.
        for (int it = 0; it < 10; it++) begin
            int len;
            int bp;
            len = int'($urandom_range(1, 40));
            start_win(len, 1'b0);
            feed(len, (it % 2 == 0) ? 0 : 4);
            scan_wait();
            check_result("rnd");
            bp = int'($urandom_range(0, 3));
            for (int i = 0; i < bp; i++) begin
                spikes_in = CH'($urandom);
                @(negedge clk);
                check_eq("rnd_bp_count", int'(res_count), exp_cnt);
            end
            handshake_idle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
